// File: rtl/param_data_memory.sv
// param_data_memory: byte-addressed data memory with per-byte write enables, registered read and range fault.
// Define DMEM_CLEAR_ON_RESET_EN to add the post-reset clear sequencer that zeroes every byte before Ready.
//
// state | meaning
// CLEAR | writing 0x00 to byte clearPtr each cycle, Ready=0, requests ignored
// RUN   | Ready=1, reads/writes served

module param_data_memory #(
    parameter int BYTES_PER_WORD = 3,
    parameter int ADDR_WIDTH     = 24,
    parameter int DEPTH_BYTES    = 128,
    parameter bit BIG_ENDIAN     = 1'b1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [ADDR_WIDTH-1:0]         Address,
    input  logic [8*BYTES_PER_WORD-1:0]   WriteData,
    input  logic [BYTES_PER_WORD-1:0]     ByteEnable,
    input  logic                          MemWrite,
    input  logic                          MemRead,
    output logic                          Ready,
    output logic [8*BYTES_PER_WORD-1:0]   ReadData,
    output logic                          ReadValid,
    output logic                          Fault
);

    localparam int W     = 8 * BYTES_PER_WORD;
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int SUM_W = ADDR_WIDTH + 1;

    logic [7:0]       memBytes [DEPTH_BYTES];
    logic             ready;
    logic [SUM_W-1:0] lastAddr;
    logic             inRange;
    logic             accept;
    logic [IDX_W-1:0] byteIdx [BYTES_PER_WORD];
    logic [W-1:0]     wordRead;

`ifdef DMEM_CLEAR_ON_RESET_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t           state;
    logic [IDX_W-1:0] clearPtr;
`endif

    // Bit position of word byte i inside the data word.
    function automatic int laneLsb(input int i);
        return BIG_ENDIAN ? 8 * (BYTES_PER_WORD - 1 - i) : 8 * i;
    endfunction

    // One extra bit keeps the end-of-word address from wrapping near the top of the address space.
    always_comb begin
        lastAddr = {1'b0, Address} + SUM_W'(BYTES_PER_WORD - 1);
        inRange  = lastAddr < SUM_W'(DEPTH_BYTES);
        accept   = ready && !Reset;
    end

    always_comb begin
        wordRead = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            byteIdx[i] = IDX_W'({1'b0, Address} + SUM_W'(i));
            wordRead[laneLsb(i) +: 8] = memBytes[byteIdx[i]];
        end
    end

    always_ff @(posedge Clock) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (!Reset && state == CLEAR)
            memBytes[clearPtr] <= 8'h00;
`endif
        if (accept && MemWrite && inRange) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (ByteEnable[i])
                    memBytes[byteIdx[i]] <= WriteData[laneLsb(i) +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ready     <= 1'b0;
            ReadValid <= 1'b0;
            ReadData  <= '0;
            Fault     <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            state     <= CLEAR;
            clearPtr  <= '0;
`endif
        end else begin
            ReadValid <= 1'b0;
            Fault     <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            case (state)
                CLEAR: begin
                    ready <= 1'b0;
                    if (clearPtr == IDX_W'(DEPTH_BYTES - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        clearPtr <= clearPtr + 1'b1;
                    end
                end
                RUN:     ready <= 1'b1;
                default: state <= CLEAR;
            endcase
`else
            ready <= 1'b1;
`endif
            if (ready) begin
                if (MemRead) begin
                    ReadValid <= 1'b1;
                    ReadData  <= inRange ? wordRead : '0;
                end
                Fault <= (MemRead || MemWrite) && !inRange;
            end
        end
    end

    assign Ready = ready;

endmodule
